// File: rtl/sb_incr_initiator.sv
// sb_incr_initiator
//   Self-contained traffic initiator and checker for the switchboard packet
//   stream. It sends NPKT numbered packets out of the TX port into an
//   increment DUT. It checks every response on the RX port: each data byte
//   must come back +1 (mod 256), and dest and last must be unchanged.
//
// Ports
//   clk, nreset      clock, synchronous active-low reset
//   start            begin a run (honoured in IDLE or DONE)
//   tx_*             outgoing packet stream (data/dest/last/valid, ready in)
//   rx_*             returning packet stream (data/dest/last/valid in, ready out)
//   busy, done       run in progress / run finished
//   pass             finished with no errors and no watchdog expiry
//   err_count        mismatched or unsolicited beats, saturating
//   rx_count         responses accepted in the current run
//   timeout          watchdog fired
//
// Optional feature
//   SB_INIT_TIMEOUT_EN: adds an idle watchdog of TIMEOUT cycles. It runs
//   while responses are outstanding and ends the run early when it expires.
module sb_incr_initiator #(
    parameter int          DW      = 256,
    parameter int          NPKT    = 16,
    parameter int          MAX_OUT = 4,
    parameter logic [31:0] DEST    = 32'h0,
    parameter int          TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    output logic [DW-1:0] tx_data,
    output logic [31:0]   tx_dest,
    output logic          tx_last,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic [31:0]   rx_dest,
    input  logic          rx_last,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_count,
    output logic [15:0]   rx_count,
    output logic          timeout
);
    localparam int NB = DW / 8;
    // One spare bit so that tx_cnt + 1 never overflows, even at NPKT = 65535.
    localparam int CW = 17;
    localparam logic [CW-1:0] NPKT_C    = CW'(NPKT);
    localparam logic [CW-1:0] LAST_C    = CW'(NPKT - 1);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   tx_cnt_reg, rx_cnt_reg;
    logic [15:0]     err_reg;
    logic            timeout_reg;

    logic            in_run, start_run;
    logic            tx_fire, rx_fire, rx_expected, rx_bad, final_rx, wd_fire;
    logic [NB-1:0]   byte_bad;
    logic [DW-1:0]   pkt_data;

    assign in_run    = (state_reg == RUN);
    assign start_run = !in_run && start;

    // Packet contents depend on tx_cnt alone, so they hold steady during a stall.
    // They are forced to zero outside RUN so that all outputs read 0 after reset.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
            assign pkt_data[gi*8 +: 8] = tx_cnt_reg[7:0] + 8'(gi);
            assign byte_bad[gi] = rx_data[gi*8 +: 8] != (rx_cnt_reg[7:0] + 8'(gi + 1));
        end
    endgenerate

    assign tx_valid = in_run && (tx_cnt_reg < NPKT_C)
                      && ((tx_cnt_reg - rx_cnt_reg) < MAX_OUT_C);
    assign tx_data  = in_run ? pkt_data : '0;
    assign tx_dest  = in_run ? (DEST + 32'(tx_cnt_reg)) : 32'h0;
    assign tx_last  = in_run && (tx_cnt_reg == LAST_C);
    assign tx_fire  = tx_valid && tx_ready;

    assign rx_ready = in_run;
    assign rx_fire  = rx_valid && rx_ready;
    // A beat is expected if it matches a packet already sent. It also counts
    // if it matches the packet being sent this same cycle (pass-through DUT).
    assign rx_expected = rx_cnt_reg < (tx_cnt_reg + CW'(tx_fire));
    assign rx_bad   = (|byte_bad)
                      || (rx_dest != (DEST + 32'(rx_cnt_reg)))
                      || (rx_last != (rx_cnt_reg == LAST_C));
    assign final_rx = rx_fire && rx_expected && (rx_cnt_reg == LAST_C);

`ifdef SB_INIT_TIMEOUT_EN
    logic [15:0] idle_reg;

    // Counts cycles with responses outstanding and nothing arriving.
    assign wd_fire = in_run && !rx_fire && (tx_cnt_reg != rx_cnt_reg)
                     && (idle_reg == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!nreset) begin
            idle_reg <= '0;
        end else if (!in_run || rx_fire || (tx_cnt_reg == rx_cnt_reg)) begin
            idle_reg <= '0;
        end else if (!wd_fire) begin
            idle_reg <= idle_reg + 16'd1;
        end
    end
`else
    // No watchdog: TIMEOUT has no effect in this build.
    assign wd_fire = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (final_rx || wd_fire) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            tx_cnt_reg  <= '0;
            rx_cnt_reg  <= '0;
            err_reg     <= '0;
            timeout_reg <= 1'b0;
        end else if (start_run) begin
            tx_cnt_reg  <= '0;
            rx_cnt_reg  <= '0;
            err_reg     <= '0;
            timeout_reg <= 1'b0;
        end else if (in_run) begin
            if (tx_fire) begin
                tx_cnt_reg <= tx_cnt_reg + CW'(1);
            end
            if (rx_fire && rx_expected) begin
                rx_cnt_reg <= rx_cnt_reg + CW'(1);
            end
            // An unsolicited beat, or a bad expected one, costs exactly one error.
            if (rx_fire && (!rx_expected || rx_bad) && (err_reg != 16'hFFFF)) begin
                err_reg <= err_reg + 16'd1;
            end
            if (wd_fire) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign busy      = in_run;
    assign done      = (state_reg == DONE);
    assign pass      = done && (err_reg == 16'h0) && !timeout_reg;
    assign err_count = err_reg;
    assign rx_count  = rx_cnt_reg[15:0];
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_sb_incr_initiator.sv
`timescale 1ns/1ps
module tb_sb_incr_initiator;
    localparam int          DW      = 64;
    localparam int          NB      = DW / 8;
    localparam int          NPKT    = 16;
    localparam int          MAX_OUT = 4;
    localparam int          TIMEOUT = 100;
    localparam logic [31:0] DEST    = 32'hFFFF_FFF8;  // wraps at packet 8

    localparam int M_COMB_INC  = 0;
    localparam int M_COMB_PASS = 1;
    localparam int M_QUEUE     = 2;

    logic          clk = 1'b0, nreset = 1'b0, start = 1'b0;
    logic [DW-1:0] tx_data, rx_data;
    logic [31:0]   tx_dest, rx_dest;
    logic          tx_last, tx_valid, tx_ready, rx_last, rx_valid, rx_ready;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count, rx_count;

    always #5 clk = ~clk;

    sb_incr_initiator #(
        .DW(DW), .NPKT(NPKT), .MAX_OUT(MAX_OUT), .DEST(DEST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .nreset(nreset), .start(start),
        .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last),
        .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .rx_count(rx_count), .timeout(timeout)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   dest;
        logic          last;
    } beat_t;

    int checks = 0;
    int errors = 0;

    beat_t exp_q[$];   // expected TX packets (scoreboard)
    beat_t rsp_q[$];   // responses held by the emulated DUT

    int mode = M_COMB_INC;
    int tx_pct = 100, rx_pct = 100, hold_cycles = 0, drop_from = -1;
    bit inject = 1'b0;
    int model_cyc = 0, m_tx = 0;
    int mon_tx = 0, mon_rx = 0, first_rx_tx = -1, gcyc = 0, last_rx_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet k from the packet rules, with every byte shifted by add.
    function automatic logic [DW-1:0] ref_pkt(input int k, input int add);
        logic [DW-1:0] d = '0;
        for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'((k + i + add) % 256);
        return d;
    endfunction

    function automatic logic [DW-1:0] incr_bytes(input logic [DW-1:0] v);
        logic [DW-1:0] d = '0;
        for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'((int'(v[i*8 +: 8]) + 1) % 256);
        return d;
    endfunction

    // Emulated DUT: drives its inputs just after the falling edge.
    initial begin
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_dest = '0; rx_last = 1'b0;
        forever begin
            @(negedge clk); #2;
            model_cyc++;
            if (mode == M_COMB_INC || mode == M_COMB_PASS) begin
                tx_ready = 1'b1;
                rx_valid = tx_valid;
                rx_data  = (mode == M_COMB_INC) ? incr_bytes(tx_data) : tx_data;
                rx_dest  = tx_dest;
                rx_last  = tx_last;
            end else begin
                tx_ready = ($urandom_range(99) < tx_pct);
                rx_valid = 1'b0;
                if (inject && busy) begin
                    tx_ready = 1'b0;
                    rx_valid = 1'b1;
                    rx_data = ref_pkt(0, 1); rx_dest = DEST; rx_last = 1'b0;
                end else if (rsp_q.size() > 0 && model_cyc > hold_cycles
                             && $urandom_range(99) < rx_pct) begin
                    rx_valid = 1'b1;
                    rx_data = rsp_q[0].data; rx_dest = rsp_q[0].dest; rx_last = rsp_q[0].last;
                end
            end
            if (!nreset) begin
                rsp_q.delete();
            end else if (mode == M_QUEUE) begin
                if (tx_valid && tx_ready) begin
                    if (drop_from < 0 || m_tx < drop_from)
                        rsp_q.push_back('{incr_bytes(tx_data), tx_dest, tx_last});
                    m_tx++;
                end
                if (rx_valid && rx_ready) begin
                    if (inject) inject = 1'b0;
                    else void'(rsp_q.pop_front());
                end
            end
        end
    end

    // Monitor: samples just before the rising edge.
    initial begin
        logic [DW-1:0] h_data;
        logic [31:0]   h_dest;
        logic          h_last;
        bit            held;
        bit            txf;
        beat_t         e;
        held = 1'b0;
        forever begin
            @(negedge clk); #4;
            gcyc++;
            if (!nreset) begin
                held = 1'b0;
                continue;
            end
            txf = tx_valid && tx_ready;
            if (tx_valid) begin
                check("outstanding_limit", 64'((mon_tx - mon_rx) < MAX_OUT), 64'd1);
                if (held) begin
                    check("stall_data", tx_data, h_data);
                    check("stall_dest", 64'(tx_dest), 64'(h_dest));
                    check("stall_last", 64'(tx_last), 64'(h_last));
                end
            end
            if (rx_valid && rx_ready && (mon_rx < mon_tx + int'(txf))) begin
                if (first_rx_tx < 0) first_rx_tx = mon_tx;
                mon_rx++;
                last_rx_cyc = gcyc;
            end
            if (txf) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_extra: got packet dest %0h expected no packet", tx_dest);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("tx%0d_data", mon_tx), tx_data, e.data);
                    check($sformatf("tx%0d_dest", mon_tx), 64'(tx_dest), 64'(e.dest));
                    check($sformatf("tx%0d_last", mon_tx), 64'(tx_last), 64'(e.last));
                end
                mon_tx++;
                held = 1'b0;
            end else if (tx_valid) begin
                held = 1'b1; h_data = tx_data; h_dest = tx_dest; h_last = tx_last;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic start_run(input int m, input int tp, input int rp, input int hold,
                             input int drop, input bit inj);
        @(negedge clk);
        mode = m; tx_pct = tp; rx_pct = rp; hold_cycles = hold; drop_from = drop; inject = inj;
        rsp_q.delete(); exp_q.delete();
        for (int k = 0; k < NPKT; k++)
            exp_q.push_back('{ref_pkt(k, 0), DEST + 32'(k), k == NPKT - 1});
        mon_tx = 0; mon_rx = 0; first_rx_tx = -1; m_tx = 0;
        start = 1'b1; model_cyc = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, inout int cyc);
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_done: got done=0 after %0d cycles expected done=1", name, cyc);
        end
    endtask

    task automatic end_check(input string name, input bit e_pass, input int e_err,
                             input int e_rx, input bit e_to);
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_pass"}, 64'(pass), 64'(e_pass));
        check({name, "_err"}, 64'(err_count), 64'(e_err));
        check({name, "_rxcnt"}, 64'(rx_count), 64'(e_rx));
        check({name, "_timeout"}, 64'(timeout), 64'(e_to));
        $display("run %s: rx_count=%0d err_count=%0d pass=%0b", name, rx_count, err_count, pass);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check({name, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_pass"}, 64'(pass), 64'd0);
        check({name, "_err"}, 64'(err_count), 64'd0);
        check({name, "_rxcnt"}, 64'(rx_count), 64'd0);
        check({name, "_timeout"}, 64'(timeout), 64'd0);
        check({name, "_tx_data"}, tx_data, 64'd0);
        check({name, "_tx_dest"}, 64'(tx_dest), 64'd0);
        check({name, "_tx_last"}, 64'(tx_last), 64'd0);
    endtask

    initial begin
        int cyc;
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        nreset = 1'b1;
        @(negedge clk);

        // Combinational +1 DUT: one beat per cycle, done 17 cycles after start.
        start_run(M_COMB_INC, 100, 100, 0, -1, 1'b0);
        check("comb_first_tx_valid", 64'(tx_valid), 64'd1);
        cyc = 1;
        wait_done("comb", cyc);
        check("comb_done_cycle", 64'(cyc), 64'd17);
        check("comb_tx_beats", 64'(mon_tx), 64'(NPKT));
        end_check("comb", 1'b1, 0, NPKT, 1'b0);

        // Pass-through without increment: every packet is wrong once.
        start_run(M_COMB_PASS, 100, 100, 0, -1, 1'b0);
        cyc = 1;
        wait_done("passthru", cyc);
        end_check("passthru", 1'b0, NPKT, NPKT, 1'b0);

        // Responses withheld for 20 cycles: exactly MAX_OUT beats go out first.
        start_run(M_QUEUE, 100, 100, 20, -1, 1'b0);
        cyc = 1;
        wait_done("hold", cyc);
        check("hold_tx_before_rx", 64'(first_rx_tx), 64'(MAX_OUT));
        check("hold_tx_beats", 64'(mon_tx), 64'(NPKT));
        end_check("hold", 1'b1, 0, NPKT, 1'b0);

        // Random back-pressure on both sides.
        for (int r = 0; r < 3; r++) begin
            start_run(M_QUEUE, 50, 50, 0, -1, 1'b0);
            cyc = 1;
            wait_done("random", cyc);
            check("random_tx_beats", 64'(mon_tx), 64'(NPKT));
            end_check("random", 1'b1, 0, NPKT, 1'b0);
        end

        // One unsolicited beat before anything is sent.
        start_run(M_QUEUE, 100, 70, 0, -1, 1'b1);
        cyc = 1;
        wait_done("unsolicited", cyc);
        end_check("unsolicited", 1'b0, 1, NPKT, 1'b0);

        // Reset in the middle of a run.
        start_run(M_QUEUE, 60, 60, 0, -1, 1'b0);
        cyc = 0;
        while (rx_count < 16'd5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("midrun_reached5", 64'(rx_count >= 16'd5), 64'd1);
        nreset = 1'b0;
        exp_q.delete(); mon_tx = 0; mon_rx = 0;
        @(negedge clk);
        nreset = 1'b1;
        check_idle_outputs("midrun_reset");
        start_run(M_QUEUE, 60, 60, 0, -1, 1'b0);
        cyc = 1;
        wait_done("after_reset", cyc);
        check("after_reset_tx_beats", 64'(mon_tx), 64'(NPKT));
        end_check("after_reset", 1'b1, 0, NPKT, 1'b0);

`ifdef SB_INIT_TIMEOUT_EN
        // DUT stops answering from packet 3 on: the watchdog ends the run.
        start_run(M_QUEUE, 100, 100, 0, 3, 1'b0);
        cyc = 1;
        wait_done("watchdog", cyc);
        check("watchdog_gap_ok",
              64'((gcyc - last_rx_cyc) >= TIMEOUT - 3 && (gcyc - last_rx_cyc) <= TIMEOUT + 3),
              64'd1);
        end_check("watchdog", 1'b0, 0, 3, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_incr_initiator.md
Name: sb_incr_initiator

Overview:
- Synthesizable traffic initiator and checker for the switchboard packet stream (data/dest/last/valid/ready).
- Drives a numbered sequence of packets into a packet-modifying DUT on its TX port.
- Collects the DUT's responses on its RX port and checks that every data byte came back incremented by 1 (mod 256), with dest and last unchanged.
- Sits on the opposite side of an increment/loopback DUT, in place of external queue processes, so self-checking runs without a host.

Parameters:
- DW, 256, data width in bits; multiple of 8; NB = DW/8 bytes.
- NPKT, 16, packets per run; 1..65535.
- MAX_OUT, 4, maximum outstanding packets (sent minus received); at least 1.
- DEST, 32'h0, base destination; packet k uses DEST+k (32-bit wrap).
- TIMEOUT, 1024, watchdog cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- nreset  in  1  synchronous active-low reset.
- start  in  1  begin a run; sampled in IDLE or DONE.
- tx_data  out  DW  outgoing packet data.
- tx_dest  out  32  outgoing destination.
- tx_last  out  1  outgoing last flag.
- tx_valid  out  1  outgoing valid.
- tx_ready  in  1  DUT ready.
- rx_data  in  DW  response data.
- rx_dest  in  32  response destination.
- rx_last  in  1  response last flag.
- rx_valid  in  1  response valid.
- rx_ready  out  1  initiator ready.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count==0 and timeout==0.
- err_count  out  16  mismatch/unsolicited count; saturates at 16'hFFFF.
- rx_count  out  16  responses accepted.
- timeout  out  1  watchdog fired.

Behaviour:
- Clocking and reset: single clock, synchronous active-low reset nreset. nreset=0 at any time, including mid-run, moves the block to IDLE at the next edge. All outputs read 0 after reset, tx_data/tx_dest included. Internal tx_cnt and rx_cnt are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN. On that edge tx_cnt, rx_cnt, err_count and timeout are cleared.
  - RUN: when rx_cnt reaches NPKT -> DONE. Entry to DONE happens on the edge that accepts the final response, so done is high the next cycle.
  - DONE: outputs hold. start=1 -> RUN with counters cleared, same as from IDLE.
- Packet k format (k = tx_cnt):
  - byte i of tx_data = (k+i) mod 256, for i in 0..NB-1.
  - tx_dest = DEST+k.
  - tx_last = (k==NPKT-1).
- TX handshake:
  - tx_valid = RUN && tx_cnt<NPKT && (tx_cnt-rx_cnt)<MAX_OUT.
  - Fire = tx_valid && tx_ready; tx_cnt increments on fire.
  - tx_data/dest/last derive from tx_cnt only, so they are stable while stalled.
  - tx_valid never drops without a fire unless reset occurs.
  - First tx_valid appears the cycle after start is sampled.
- RX handshake:
  - rx_ready = RUN, registered state only; there is no combinational path from tx_ready or rx_valid.
  - Fire = rx_valid && rx_ready.
  - A beat is expected when rx_cnt < tx_cnt + tx_fire. The same-cycle case supports a combinational pass-through DUT.
  - Expected beat: compare against packet rx_cnt with every byte +1 mod 256, dest DEST+rx_cnt, last (rx_cnt==NPKT-1). Any mismatch adds 1 to err_count; at most 1 per packet. rx_cnt then increments.
  - Unexpected beat: err_count+1; the beat is discarded and rx_cnt is unchanged.
- err_count saturates at 16'hFFFF and never wraps.
- With MAX_OUT reached and no response, the block stalls in RUN indefinitely unless the optional feature is compiled in.

Optional Feature:
- Macro: SB_INIT_TIMEOUT_EN.
- With the macro:
  - A 16-bit idle counter runs in RUN while tx_cnt>rx_cnt.
  - It clears on any rx fire and counts otherwise.
  - When it reaches TIMEOUT: timeout=1 and the FSM goes to DONE, so pass=0. done rises the cycle after.
  - The counter is cleared on start and on reset.
- Without the macro: timeout is tied to 0, no counter logic is present, and the TIMEOUT parameter is ignored.

Test Plan:
- Combinational +1 DUT, tx_ready=1, NPKT=16: 16 back-to-back tx beats, 1 per cycle from cycle start+1; done at cycle start+17; pass=1; err_count=0; rx_count=16.
- Pass-through DUT with no increment: done=1, pass=0, err_count=16, rx_count=16.
- Registered DUT that withholds responses for 20 cycles, MAX_OUT=4: exactly 4 tx beats, then tx_valid=0 until the first rx fire, then tx resumes; final pass=1.
- Random tx_ready (50%) and random rx_valid gating: tx_data/dest/last stable across stalls; packet 5 byte 0=8'h05 sent, 8'h06 returned; pass=1.
- nreset low for 1 cycle after 5 accepted packets: next cycle tx_valid=0, rx_ready=0, busy=0, err_count=0, rx_count=0; then start -> full run, pass=1.
- SB_INIT_TIMEOUT_EN defined, TIMEOUT=100, DUT drops packet 3: timeout=1 and done=1 about 100 cycles after the last response; pass=0; rx_count=3.
